draw_queue: RTL and testbench
=============================

DRAW_QUEUE -- requirements
Module: draw_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of queued draw requests (power of 2, 2..16).
REQ-002 SHALL have parameter HOLD_CYCLES, default 2, the number of cycles start is held high per request (1..15).
REQ-003 SHALL have parameter BUSY_CYCLES, default 48, the number of cycles waited after start falls before the next issue (1..255).
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port push, input, 1 bit: enqueue request, one entry per cycle.
REQ-007 SHALL have port push_data, input, 16 bits: packed coordinate, x in [15:8] and y in [7:0].
REQ-008 SHALL have port full, output, 1 bit: high when count equals DEPTH.
REQ-009 SHALL have port count, output, $clog2(DEPTH+1) bits: number of stored entries.
REQ-010 SHALL have port start, output, 1 bit: go strobe to the downstream square drawer.
REQ-011 SHALL have port out, output, 16 bits: coordinate presented to the drawer's in port.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL implement a circular FIFO of DEPTH x 16-bit entries, with read and write pointers that wrap modulo DEPTH.
REQ-014 SHALL implement an FSM with states IDLE, ISSUE and SETTLE, plus a shared 8-bit down-counter.
REQ-015 IDLE with count>0 SHALL pop the head into out, load the counter with HOLD_CYCLES-1 and go to ISSUE on the next edge; IDLE with count==0 SHALL stay in IDLE.
REQ-016 ISSUE SHALL drive start=1 and hold out stable; when the counter is 0 it SHALL load BUSY_CYCLES-1 and go to SETTLE, otherwise it SHALL decrement.
REQ-017 SHALL hold start=0 and out stable in SETTLE; when the counter is 0 it SHALL go to IDLE, otherwise it SHALL decrement.
REQ-018 Latency: a push accepted at edge n into an empty, idle queue SHALL give start=1 from cycle n+1, for exactly HOLD_CYCLES cycles.
REQ-019 Request spacing: consecutive start rising edges SHALL be exactly HOLD_CYCLES+BUSY_CYCLES+1 cycles apart while the queue is non-empty.
REQ-020 A push when full and with no pop that cycle SHALL be dropped; the pointers, contents and count SHALL be unchanged.
REQ-021 A push and a pop on the same edge SHALL both take effect with count unchanged, including when full.
REQ-022 A push and a pop on the same edge when count==0 SHALL have no effect on the pop: the pop occurs only if count>0 before the edge.
REQ-023 start SHALL be a registered output, glitch-free.
REQ-024 out SHALL change only on the IDLE-to-ISSUE edge.

Reset
REQ-025 On reset, SHALL set state=IDLE, pointers=0, count=0, counter=0, start=0, out=16'h0000, full=0 and busy=0.
REQ-026 Reset mid-ISSUE or mid-SETTLE SHALL abort the request and discard queued entries; start SHALL be 0 in the cycle after the reset edge.
REQ-027 push SHALL be ignored on any edge where reset=1.

Configuration
REQ-028 With DRAW_QUEUE_DROP_CNT_EN defined, SHALL add output drop_count (8 bits, saturating at 255, reset to 0) that increments on each push dropped per REQ-020.
REQ-029 Without DRAW_QUEUE_DROP_CNT_EN, drop_count and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 Package draw_pkg SHALL hold the FSM state enum (IDLE, ISSUE, SETTLE), the coordinate typedef (16 bits, x/y halves) and the default HOLD/BUSY constants.
REQ-031 Storage SHALL be in sub-module draw_fifo (push/pop/full/count), with the FSM in draw_queue.

Verification
REQ-032 Bench SHALL cover: reset, push 16'h1020 once -> start high in cycles 1-2 after the push, out=16'h1020, busy low 51 cycles after the push.
REQ-033 Bench SHALL cover: push 16'h0101, 16'h0202, 16'h0303 back-to-back -> start rising edges 51 cycles apart, with out values in push order.
REQ-034 Bench SHALL cover: fill with 5 pushes while the FSM is held off (no pop) and DEPTH=4 -> full=1, count=4, fifth entry absent from outputs, drop_count=1 when the macro is defined.
REQ-035 Bench SHALL cover: push on the same edge as a pop with full=1 -> count stays 4 and the new entry is issued fourth.
REQ-036 Bench SHALL cover: reset asserted in ISSUE with 2 entries queued -> next cycle start=0, count=0, out=0, and no further starts.
REQ-037 Bench SHALL cover: count wrap over 20 push/pop cycles -> out sequence matches the push sequence exactly.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types and defaults for the draw request queue.
// The optional drop counter is enabled with DRAW_QUEUE_DROP_CNT_EN (see draw_queue.sv).
package draw_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } draw_state_e;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } coord_t;

    localparam int unsigned COORD_W             = 16;
    localparam int unsigned TIMER_W             = 8;
    localparam int unsigned DEFAULT_HOLD_CYCLES = 2;
    localparam int unsigned DEFAULT_BUSY_CYCLES = 48;

endpackage

// File: rtl/draw_fifo.sv
// Circular FIFO holding queued draw coordinates; pointers wrap modulo DEPTH.
// A push while full is dropped unless a pop happens on the same edge.
module draw_fifo
    import draw_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [15:0]                  push_data,
    input  logic                         pop,
    output logic [15:0]                  pop_data,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    coord_t             mem_q [DEPTH];
    coord_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;
    logic               is_full;
    logic               is_empty;

    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);

    // A pop frees a slot on the same edge, so a full FIFO can still accept.
    assign do_pop  = pop && !is_empty;
    assign do_push = push && (!is_full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = coord_t'(push_data);
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_q <= mem_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = is_full;
    assign count    = count_q;

endmodule

// File: rtl/draw_queue.sv
// Queues draw requests and paces them to a square drawer: start held HOLD_CYCLES, then
// BUSY_CYCLES of settle before the next issue. Define DRAW_QUEUE_DROP_CNT_EN for drop_count.
module draw_queue
    import draw_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int unsigned BUSY_CYCLES = DEFAULT_BUSY_CYCLES
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [15:0]                  push_data,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         start,
    output logic [15:0]                  out,
    output logic                         busy
`ifdef DRAW_QUEUE_DROP_CNT_EN
    ,
    output logic [7:0]                   drop_count
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    draw_state_e          state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 start_q, start_d;
    coord_t               out_q, out_d;
    logic                 pop;
    logic [15:0]          head_data;
    logic                 fifo_full;
    logic [CNT_W-1:0]     fifo_count;

    draw_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head_data),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        out_d   = out_q;
        pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    out_d   = coord_t'(head_data);
                    timer_d = TIMER_W'(HOLD_CYCLES - 1);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (timer_q == '0) begin
                    timer_d = TIMER_W'(BUSY_CYCLES - 1);
                    state_d = SETTLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            SETTLE: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        // Registering the look-ahead keeps start aligned with the ISSUE state.
        start_d = (state_d == ISSUE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            start_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            start_q <= start_d;
            out_q   <= out_d;
        end
    end

`ifdef DRAW_QUEUE_DROP_CNT_EN
    logic [7:0] drop_count_q, drop_count_d;
    logic       dropped;

    assign dropped = push && fifo_full && !pop;

    always_comb begin
        drop_count_d = drop_count_q;
        if (dropped && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

    assign start = start_q;
    assign out   = out_q;
    assign busy  = (state_q != IDLE);
    assign full  = fifo_full;
    assign count = fifo_count;

endmodule

// File: tb/tb_draw_queue.sv
// Directed bench for draw_queue with default parameters (DEPTH 4, HOLD 2, BUSY 48).
module tb_draw_queue;

    logic        clock;
    logic        reset;
    logic        push;
    logic [15:0] push_data;
    logic        full;
    logic [2:0]  count;
    logic        start;
    logic [15:0] out;
    logic        busy;
`ifdef DRAW_QUEUE_DROP_CNT_EN
    logic [7:0]  drop_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    draw_queue dut (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .count     (count),
        .start     (start),
        .out       (out),
        .busy      (busy)
`ifdef DRAW_QUEUE_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ticks until start rises (0 -> 1), giving up after max_cycles.
    task automatic wait_rise(input int max_cycles, output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = start;
        for (int k = 0; k < max_cycles; k++) begin
            tick();
            if (!prev && start) begin
                ok = 1'b1;
                return;
            end
            prev = start;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          ok;
        bit          seen;
        logic [15:0] seq [20];

        reset     = 1'b1;
        push      = 1'b0;
        push_data = 16'h0000;
        ticks(2);
        check("rst_start", start, 0);
        check("rst_out", out, 16'h0000);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
`ifdef DRAW_QUEUE_DROP_CNT_EN
        check("rst_drop", drop_count, 0);
`endif
        reset = 1'b0;
        tick();

        // Single request: start in cycles n+1, n+2; idle again at n+51.
        push = 1'b1; push_data = 16'h1020;
        tick();
        push = 1'b0;
        check("t1_count", count, 1);
        check("t1_start_n", start, 0);
        tick();
        check("t1_start_n1", start, 1);
        check("t1_out", out, 16'h1020);
        check("t1_busy", busy, 1);
        check("t1_count_pop", count, 0);
        tick();
        check("t1_start_n2", start, 1);
        tick();
        check("t1_start_n3", start, 0);
        ticks(47);
        check("t1_busy_n50", busy, 1);
        tick();
        check("t1_busy_n51", busy, 0);
        check("t1_out_hold", out, 16'h1020);

        // Three back-to-back pushes: issues 51 cycles apart in push order.
        push = 1'b1; push_data = 16'h0101;
        tick();
        push_data = 16'h0202;
        tick();
        check("t2_start_a", start, 1);
        check("t2_out_a", out, 16'h0101);
        push_data = 16'h0303;
        tick();
        push = 1'b0;
        check("t2_count", count, 2);
        ticks(49);
        check("t2_gap_b", start, 0);
        tick();
        check("t2_start_b", start, 1);
        check("t2_out_b", out, 16'h0202);
        check("t2_count_b", count, 1);
        ticks(50);
        check("t2_gap_c", start, 0);
        tick();
        check("t2_start_c", start, 1);
        check("t2_out_c", out, 16'h0303);
        ticks(50);
        check("t2_idle", busy, 0);

        // Fill while busy: 4 of 5 accepted, then push on the pop edge while full.
        push = 1'b1; push_data = 16'hA001;
        tick();
        push = 1'b0;
        tick();
        check("t3_out_a", out, 16'hA001);
        push = 1'b1;
        push_data = 16'hB002; tick();
        push_data = 16'hC003; tick();
        push_data = 16'hD004; tick();
        push_data = 16'hE005; tick();
        push_data = 16'hF006; tick();
        push = 1'b0;
        check("t3_full", full, 1);
        check("t3_count", count, 4);
`ifdef DRAW_QUEUE_DROP_CNT_EN
        check("t3_drop", drop_count, 1);
`endif
        ticks(45);
        check("t3_idle", busy, 0);
        check("t3_count_idle", count, 4);
        push = 1'b1; push_data = 16'h6007;
        tick();
        push = 1'b0;
        check("t3_start_b", start, 1);
        check("t3_out_b", out, 16'hB002);
        check("t3_count_same", count, 4);
        check("t3_full_same", full, 1);
`ifdef DRAW_QUEUE_DROP_CNT_EN
        check("t3_drop_same", drop_count, 1);
`endif
        ticks(51);
        check("t3_out_c", out, 16'hC003);
        check("t3_count_c", count, 3);
        ticks(51);
        check("t3_out_d", out, 16'hD004);
        ticks(51);
        check("t3_out_e", out, 16'hE005);
        ticks(51);
        check("t3_start_g", start, 1);
        check("t3_out_g", out, 16'h6007);
        check("t3_count_g", count, 0);
        ticks(51);
        check("t3_no_f", busy, 0);
        check("t3_out_last", out, 16'h6007);

        // Reset during ISSUE with two queued entries; push on the reset edge is ignored.
        push = 1'b1; push_data = 16'h1111;
        tick();
        push_data = 16'h2222;
        tick();
        push_data = 16'h3333;
        tick();
        check("t4_count", count, 2);
        check("t4_in_issue", start, 1);
        reset = 1'b1; push_data = 16'h4444;
        tick();
        reset = 1'b0; push = 1'b0;
        check("t4_start", start, 0);
        check("t4_count_rst", count, 0);
        check("t4_out", out, 16'h0000);
        check("t4_busy", busy, 0);
        check("t4_full", full, 0);
        seen = 1'b0;
        for (int k = 0; k < 120; k++) begin
            tick();
            if (start) seen = 1'b1;
        end
        check("t4_no_start", seen, 0);

        // Twenty requests through the wrapping pointers, next one pushed during each issue.
        for (int i = 0; i < 20; i++) seq[i] = {8'(i * 7 + 3), 8'(255 - i)};
        push = 1'b1; push_data = seq[0];
        tick();
        push = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wait_rise(60, ok);
            check("t5_rise", ok, 1);
            check("t5_out", out, seq[i]);
            if (i < 19) begin
                push = 1'b1; push_data = seq[i + 1];
                tick();
                push = 1'b0;
            end
        end
        ticks(55);
        check("t5_idle", busy, 0);
        check("t5_count", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
